// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-channel switch synchronizer, debounce FSM, edge and long-hold pulses
// Accepts a new level after DEB_CYCLES consecutive synchronized samples; long pulse after LONG_CYCLES high.
module sw_debounce #(
  parameter int N           = 2,
  parameter int DEB_CYCLES  = 20,
  parameter int LONG_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_level,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic [N-1:0] sw_long
);

  localparam int CW = $clog2(DEB_CYCLES);
  // A zero-width hold counter is illegal, so keep one bit when long detection is disabled.
  localparam int HW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {ST_LO, WAIT_HI, ST_HI, WAIT_LO} state_t;

  logic [N-1:0] s1;
  logic [N-1:0] s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s  <= '0;
    end else begin
      s1 <= sw_raw;
      s  <= s1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    logic          level;
    logic          rise;
    logic          fall;
    logic          lng;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= ST_LO;
        cnt   <= '0;
        hcnt  <= '0;
        level <= 1'b0;
        rise  <= 1'b0;
        fall  <= 1'b0;
        lng   <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        lng  <= 1'b0;

        case (state)
          ST_LO: begin
            if (s[i]) begin
              state <= WAIT_HI;
              cnt   <= CNT_ONE;
            end
          end
          WAIT_HI: begin
            if (!s[i]) begin
              state <= ST_LO;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= ST_HI;
              level <= 1'b1;
              rise  <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_HI: begin
            if (!s[i]) begin
              state <= WAIT_LO;
              cnt   <= CNT_ONE;
            end
          end
          WAIT_LO: begin
            if (s[i]) begin
              state <= ST_HI;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= ST_LO;
              level <= 1'b0;
              fall  <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_LO;
            cnt   <= '0;
          end
        endcase

        // A release bounce (WAIT_LO) keeps the hold count so a press is never re-fired.
        if (state == ST_HI) begin
          if (LONG_CYCLES > 0 && hcnt < HOLD_MAX) begin
            hcnt <= hcnt + 1'b1;
            if (hcnt == HOLD_LAST) lng <= 1'b1;
          end
        end else if (state != WAIT_LO) begin
          hcnt <= '0;
        end
      end
    end

    assign sw_level[i] = level;
    assign sw_rise[i]  = rise;
    assign sw_fall[i]  = fall;
    assign sw_long[i]  = lng;
  end

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - self-checking bench for sw_debounce (N=2, DEB_CYCLES=4, LONG_CYCLES=8)
// Edge pulses are predicted from raw run lengths and scoreboarded; levels come from the vector table.
module tb_sw_debounce;
  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int LONG = 8;
  localparam int MAXT = 512;
  localparam int TAIL = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_level;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
  logic [N-1:0] sw_long;

  sw_debounce #(.N(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw_level(sw_level),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_long(sw_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] raw;
    int         cycles;
    logic [1:0] level;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] lng;
  } ev_t;

  vec_t       vecs[$];
  ev_t        sb[$];
  logic [1:0] raw_seq[MAXT];
  logic [1:0] e_rise[MAXT];
  logic [1:0] e_fall[MAXT];
  logic [1:0] e_long[MAXT];
  logic       rec_end[MAXT];
  logic [1:0] rec_lvl[MAXT];
  int         total_t;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] raw);
    sw_raw = raw;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {sw_level, sw_rise, sw_fall, sw_long};
  endfunction

  task automatic add(input logic [1:0] raw, input int cycles, input logic [1:0] level);
    vec_t v;
    v.raw = raw;
    v.cycles = cycles;
    v.level = level;
    vecs.push_back(v);
  endtask

  initial begin
    ev_t  ev;
    logic [5:0] exp_p;

    // Reset held with both switches high, then release and watch acceptance.
    rst = 1'b0;
    sw_raw = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", outs(), 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(2'b11);
      check($sformatf("post_reset_%0d", i), outs(),
            (i < 5) ? 8'h00 : ((i == 5) ? 8'hF0 : 8'hC0));
    end

    // Asynchronous reset in the middle of a hold count.
    rst = 1'b0;
    #1;
    check("async_reset_mid_hold", outs(), 8'h00);
    @(posedge clk);
    #1;
    check("reset_held", outs(), 8'h00);
    sw_raw = 2'b00;
    rst = 1'b1;

    add(2'b00, 6, 2'b00);
    add(2'b01, 10, 2'b01);
    add(2'b00, 10, 2'b00);
    add(2'b01, 3, 2'b00);
    add(2'b00, 1, 2'b00);
    add(2'b01, 3, 2'b00);
    add(2'b00, 8, 2'b00);
    add(2'b10, 40, 2'b10);
    add(2'b00, 10, 2'b00);
    add(2'b10, 20, 2'b10);
    add(2'b00, 10, 2'b00);
    add(2'b10, 10, 2'b10);
    add(2'b00, 10, 2'b00);
    add(2'b10, 11, 2'b10);
    add(2'b00, 10, 2'b00);
    add(2'b01, 4, 2'b00);
    add(2'b00, 4, 2'b01);
    add(2'b00, 8, 2'b00);
    add(2'b11, 2, 2'b00);
    add(2'b01, 1, 2'b00);
    add(2'b11, 10, 2'b11);
    add(2'b00, 10, 2'b00);

    total_t = 0;
    foreach (vecs[r]) begin
      for (int c = 0; c < vecs[r].cycles; c++) begin
        raw_seq[total_t] = vecs[r].raw;
        rec_end[total_t] = (c == vecs[r].cycles - 1);
        rec_lvl[total_t] = vecs[r].level;
        total_t++;
      end
    end
    for (int c = 0; c < TAIL; c++) begin
      raw_seq[total_t] = 2'b00;
      rec_end[total_t] = 1'b0;
      rec_lvl[total_t] = 2'b00;
      total_t++;
    end
    for (int t = 0; t < MAXT; t++) begin
      e_rise[t] = '0;
      e_fall[t] = '0;
      e_long[t] = '0;
    end

    // A run of L raw samples at a new value is accepted iff L >= DEB, visible DEB+1 edges after it starts.
    for (int ch = 0; ch < N; ch++) begin
      logic lvl;
      int   t;
      lvl = 1'b0;
      t = 0;
      while (t < total_t) begin
        logic v;
        int   len;
        v = raw_seq[t][ch];
        len = 0;
        while (t + len < total_t && raw_seq[t + len][ch] == v) len++;
        if (v != lvl && len >= DEB) begin
          int a;
          a = t + DEB + 1;
          if (a < MAXT) begin
            if (v) e_rise[a][ch] = 1'b1;
            else   e_fall[a][ch] = 1'b1;
          end
          if (v && len >= DEB + LONG - 1 && a + LONG < MAXT) e_long[a + LONG][ch] = 1'b1;
          lvl = v;
        end
        t += len;
      end
    end

    for (int t = 0; t < total_t; t++) begin
      if ((e_rise[t] | e_fall[t] | e_long[t]) != 2'b00) begin
        ev.cyc  = t;
        ev.rise = e_rise[t];
        ev.fall = e_fall[t];
        ev.lng  = e_long[t];
        sb.push_back(ev);
      end
    end

    for (int t = 0; t < total_t; t++) begin
      step(raw_seq[t]);
      exp_p = 6'b0;
      if (sb.size() > 0 && sb[0].cyc == t) begin
        ev = sb.pop_front();
        exp_p = {ev.rise, ev.fall, ev.lng};
      end
      check($sformatf("pulses_t%0d", t), {2'b00, sw_rise, sw_fall, sw_long}, {2'b00, exp_p});
      if (rec_end[t]) check($sformatf("level_t%0d", t), {6'b0, sw_level}, {6'b0, rec_lvl[t]});
    end
    check("scoreboard_drained", 8'(sb.size()), 8'h00);

    // Reset while ch1 is accepted high and ch0 sits in WAIT_HI.
    for (int i = 0; i < 8; i++) step(2'b10);
    for (int i = 0; i < 3; i++) step(2'b11);
    check("pre_reset_wait_hi", outs(), 8'h80);
    rst = 1'b0;
    #1;
    check("async_reset_wait_hi", outs(), 8'h00);
    @(posedge clk);
    #1;
    sw_raw = 2'b00;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(2'b00);
      check($sformatf("quiet_after_wait_hi_%0d", i), outs(), 8'h00);
    end

    // Reset during a long-hold count, then a fresh press must time its long pulse from scratch.
    for (int i = 0; i < 10; i++) step(2'b10);
    check("pre_reset_long", outs(), 8'h80);
    rst = 1'b0;
    #1;
    check("async_reset_long", outs(), 8'h00);
    @(posedge clk);
    #1;
    sw_raw = 2'b00;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(2'b00);
      check($sformatf("quiet_after_long_%0d", i), outs(), 8'h00);
    end
    for (int i = 0; i < 16; i++) begin
      step(2'b10);
      check($sformatf("fresh_press_%0d", i), outs(),
            (i < 5) ? 8'h00 : ((i == 5) ? 8'hA0 : ((i == 13) ? 8'h82 : 8'h80)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
